// File: rtl/out_uart_tx.sv
// CPU output port: captures bus bytes on load into a display latch and a small FIFO,
// then drains the FIFO as back-to-back 8N1 UART frames on tx.
module out_uart_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DEPTH        = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic [7:0]                   bus,
   output logic [7:0]                   display,
   output logic                         tx,
   output logic                         busy,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow
);

   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]        r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit;
   logic [7:0]        r_shift;
   logic              r_tx;
   logic [7:0]        r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [7:0]        r_display;
   logic              r_overflow;

   logic              w_last_baud;
   logic              w_pop;
   logic              w_push;
   logic [7:0]        w_pop_data;

   assign w_last_baud = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
   // A pop on the final stop cycle chains straight into the next start bit.
   assign w_pop       = (r_count != '0) &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last_baud));
   assign w_push      = load && ((r_count < CNT_W'(DEPTH)) || w_pop);
   assign w_pop_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_display  <= 8'h00;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
            r_display <= bus;
         end
         if (load && !w_push) begin
            r_overflow <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_tx    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_state <= S_START;
                  r_shift <= w_pop_data;
                  r_baud  <= '0;
                  r_tx    <= 1'b0;
               end
            end
            S_START: begin
               if (w_last_baud) begin
                  r_baud  <= '0;
                  r_bit   <= 3'd0;
                  r_state <= S_DATA;
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (w_last_baud) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_tx    <= r_shift[0];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (w_last_baud) begin
                  r_baud <= '0;
                  if (w_pop) begin
                     r_state <= S_START;
                     r_shift <= w_pop_data;
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign display  = r_display;
   assign tx       = r_tx;
   assign busy     = (r_state != S_IDLE);
   assign full     = (r_count == CNT_W'(DEPTH));
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: queue-based frame model checked every cycle, a line receiver
// decoding tx, and directed scenarios with hand-computed expectations.
module tb_out_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int FRAME = 10 * CPB;

   logic             clk  = 1'b0;
   logic             rst  = 1'b0;
   logic             load = 1'b0;
   logic [7:0]       bus  = 8'h00;
   logic [7:0]       display;
   logic             tx;
   logic             busy;
   logic             full;
   logic [CNT_W-1:0] count;
   logic             overflow;

   int total = 0;
   int bad   = 0;

   out_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .bus      (bus),
      .display  (display),
      .tx       (tx),
      .busy     (busy),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: FIFO as a queue, frame position as a cycle offset into a 10-bit-time frame.
   logic [7:0] m_q[$];
   logic [7:0] m_byte;
   logic [7:0] m_display;
   bit         m_active;
   bit         m_overflow;
   bit         m_pop;
   bit         m_push;
   int         m_t;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q.delete();
         m_byte     = 8'h00;
         m_display  = 8'h00;
         m_active   = 1'b0;
         m_overflow = 1'b0;
         m_t        = 0;
      end else begin
         m_pop  = (m_q.size() > 0) && (!m_active || m_t == FRAME - 1);
         m_push = load && ((m_q.size() < DEPTH) || m_pop);
         if (m_pop) m_byte = m_q.pop_front();
         if (m_push) begin
            m_q.push_back(bus);
            m_display = bus;
         end else if (load) begin
            m_overflow = 1'b1;
         end
         if (m_pop) begin
            m_active = 1'b1;
            m_t      = 0;
         end else if (m_active) begin
            if (m_t == FRAME - 1) m_active = 1'b0;
            else m_t++;
         end
      end
   end

   logic             e_tx;
   logic [CNT_W-1:0] e_count;
   int               e_ph;

   always @(negedge clk) begin
      e_ph = m_t / CPB;
      if (!m_active)      e_tx = 1'b1;
      else if (e_ph == 0) e_tx = 1'b0;
      else if (e_ph <= 8) e_tx = m_byte[e_ph-1];
      else                e_tx = 1'b1;
      e_count = CNT_W'(m_q.size());
      total++;
      if ({tx, busy, count, full, display, overflow} !==
          {e_tx, m_active, e_count, (m_q.size() == DEPTH), m_display, m_overflow}) begin
         bad++;
         $display("FAIL model t=%0t got tx=%b busy=%b count=%0d full=%b display=%h ovf=%b expected tx=%b busy=%b count=%0d full=%b display=%h ovf=%b",
                  $time, tx, busy, count, full, display, overflow,
                  e_tx, m_active, e_count, (m_q.size() == DEPTH), m_display, m_overflow);
      end
   end

   // Line receiver: samples mid-bit, relative to the first low cycle of each start bit.
   logic [7:0] rx_q[$];
   logic [7:0] rx_sh;
   bit         rx_on = 1'b0;
   int         rx_ph = 0;

   always @(negedge clk) begin
      if (!rst) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (tx === 1'b0) begin
            rx_on = 1'b1;
            rx_ph = 0;
         end
      end else begin
         rx_ph++;
         if (rx_ph >= CPB && rx_ph < 9 * CPB && (rx_ph % CPB) == CPB / 2)
            rx_sh[rx_ph/CPB-1] = tx;
         if (rx_ph == 9 * CPB + CPB / 2)
            check("stop_bit", {31'd0, tx}, 32'd1);
         if (rx_ph == FRAME - 1) begin
            rx_on = 1'b0;
            rx_q.push_back(rx_sh);
         end
      end
   end

   task automatic expect_rx(input string name, input logic [7:0] b);
      if (rx_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s got=none expected=0x%0h", name, b);
      end else begin
         check(name, {24'd0, rx_q.pop_front()}, {24'd0, b});
      end
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy !== 1'b0 || count !== '0) begin
         @(negedge clk);
         n++;
         if (n > limit) begin
            total++;
            bad++;
            $display("FAIL wait_idle got=%0d cycles expected<=%0d", n, limit);
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
   endtask

   logic a5_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      int n;
      int lows;
      logic exp_bit;

      repeat (2) @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_display", {24'd0, display}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      #2 rst = 1'b1;

      // Single byte 0xA5
      @(negedge clk);
      load = 1'b1; bus = 8'hA5;
      @(negedge clk);
      load = 1'b0;
      check("a5_display", {24'd0, display}, 32'hA5);
      check("a5_count_n", {29'd0, count}, 32'd1);
      check("a5_tx_n", {31'd0, tx}, 32'd1);
      @(negedge clk);
      check("a5_tx_start", {31'd0, tx}, 32'd0);
      check("a5_busy_start", {31'd0, busy}, 32'd1);
      check("a5_count_pop", {29'd0, count}, 32'd0);
      for (int p = 1; p < FRAME; p++) begin
         @(negedge clk);
         if ((p % CPB) == CPB / 2) begin
            if (p < CPB)          exp_bit = 1'b0;
            else if (p < 9 * CPB) exp_bit = a5_bits[p/CPB-1];
            else                  exp_bit = 1'b1;
            check("a5_bit", {31'd0, tx}, {31'd0, exp_bit});
         end
      end
      check("a5_busy_n40", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("a5_busy_n41", {31'd0, busy}, 32'd0);
      check("a5_count_end", {29'd0, count}, 32'd0);
      expect_rx("a5_rx", 8'hA5);

      // Back-to-back 0x01, 0x80, 0xFF
      @(negedge clk);
      load = 1'b1; bus = 8'h01;
      @(negedge clk);
      bus = 8'h80;
      @(negedge clk);
      check("b2b_busy_n1", {31'd0, busy}, 32'd1);
      bus = 8'hFF;
      @(negedge clk);
      load = 1'b0;
      check("b2b_count_peak", {29'd0, count}, 32'd2);
      check("b2b_display", {24'd0, display}, 32'hFF);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      // busy already counted one cycle before this point: 120 total
      check("b2b_busy_cycles", n, 3 * FRAME - 1);
      expect_rx("b2b_rx0", 8'h01);
      expect_rx("b2b_rx1", 8'h80);
      expect_rx("b2b_rx2", 8'hFF);

      // Overflow: six loads 0x10..0x15
      @(negedge clk);
      load = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus = 8'(16 + i);
         @(negedge clk);
      end
      load = 1'b0;
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_display", {24'd0, display}, 32'h14);
      check("ovf_count", {29'd0, count}, 32'd4);
      check("ovf_full", {31'd0, full}, 32'd1);
      wait_idle(400);
      for (int i = 0; i < 5; i++) expect_rx("ovf_rx", 8'(16 + i));
      check("ovf_rx_extra", rx_q.size(), 0);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Full FIFO plus push on the last stop cycle
      do_reset();
      check("full_rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      load = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus = 8'(32 + i);
         @(negedge clk);
      end
      load = 1'b0;
      check("full_count", {29'd0, count}, 32'd4);
      repeat (36) @(negedge clk);
      check("full_busy_n40", {31'd0, busy}, 32'd1);
      check("full_full_n40", {31'd0, full}, 32'd1);
      load = 1'b1; bus = 8'h25;
      @(negedge clk);
      load = 1'b0;
      check("full_pp_count", {29'd0, count}, 32'd4);
      check("full_pp_ovf", {31'd0, overflow}, 32'd0);
      check("full_pp_display", {24'd0, display}, 32'h25);
      check("full_pp_tx", {31'd0, tx}, 32'd0);
      wait_idle(400);
      for (int i = 0; i < 6; i++) expect_rx("full_rx", 8'(32 + i));

      // Reset during data bit 3 of 0x3C
      @(negedge clk);
      load = 1'b1; bus = 8'h3C;
      @(negedge clk);
      load = 1'b0;
      repeat (18) @(negedge clk);
      check("mid_busy_pre", {31'd0, busy}, 32'd1);
      #1 rst = 1'b0;
      #1;
      check("mid_tx", {31'd0, tx}, 32'd1);
      check("mid_count", {29'd0, count}, 32'd0);
      check("mid_display", {24'd0, display}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      lows = 0;
      repeat (2 * FRAME) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("mid_tx_quiet", lows, 0);
      check("mid_busy_after", {31'd0, busy}, 32'd0);
      check("mid_rx_none", rx_q.size(), 0);

      // Pointer wrap: ten single-byte frames
      for (int b = 0; b < 10; b++) begin
         @(negedge clk);
         load = 1'b1; bus = 8'(b);
         @(negedge clk);
         load = 1'b0;
         wait_idle(200);
         expect_rx("wrap_rx", 8'(b));
      end
      check("wrap_ovf", {31'd0, overflow}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
